// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and code-to-segment table for the seven-segment scan controller.
// Segment vectors are active-low with bit 0 = a through bit 6 = g.
package seg7_scan_ctrl_pkg;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Entry 15 first, entry 0 last; codes 10 and 12..15 are blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_OFF,  SEG_OFF,  SEG_OFF,  SEG_OFF,
        SEG_DASH, SEG_OFF,  7'h10,    7'h00,
        7'h78,    7'h02,    7'h12,    7'h19,
        7'h30,    7'h24,    7'h79,    7'h40
    };

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// Combinational digit-code to active-low segment decoder.
// Latency: none. Backpressure: none.
module seg7_decode
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[code];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller: per-frame snapshot, dead time, blink and dp masks.
// Latency: outputs registered, one clock after the counter state they reflect. Backpressure: none.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD_CYC     = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dp_mask,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_DEAD = PRE_W'(DEAD_CYC);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [1:0]        slot_q, slot_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              blink_q, blink_d;
    logic [3:0][3:0]   fdig_q, fdig_d;
    logic [3:0]        fblink_q, fblink_d;
    logic [3:0]        fdp_q, fdp_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic              fs_q, fs_d;

    logic              pre_wrap, slot_wrap, frm_wrap, snap;
    logic [3:0]        sel_code;
    logic [6:0]        sel_seg;

    always_comb begin
        pre_wrap  = (pre_q == PRE_LAST);
        slot_wrap = pre_wrap && (slot_q == 2'd3);
        frm_wrap  = slot_wrap && (frm_q == FRM_LAST);
        snap      = en && (pre_q == '0) && (slot_q == 2'd0);

        pre_d   = pre_q;
        slot_d  = slot_q;
        frm_d   = frm_q;
        blink_d = blink_q;
        if (!en) begin
            pre_d   = '0;
            slot_d  = '0;
            frm_d   = '0;
            blink_d = 1'b0;
        end else begin
            pre_d = pre_wrap ? '0 : pre_q + 1'b1;
            if (pre_wrap)  slot_d  = slot_q + 2'd1;
            if (slot_wrap) frm_d   = frm_wrap ? '0 : frm_q + 1'b1;
            if (frm_wrap)  blink_d = ~blink_q;
        end

        fdig_d   = snap ? {dig3, dig2, dig1, dig0} : fdig_q;
        fblink_d = snap ? blink_mask : fblink_q;
        fdp_d    = snap ? dp_mask : fdp_q;
    end

    // Decode from the next-state frame registers so the snapshot cycle shows fresh data.
    assign sel_code = fdig_d[slot_q];

    seg7_decode u_decode (
        .code (sel_code),
        .seg  (sel_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = 4'hF;
        fs_d  = snap;
        if (en && (pre_q >= PRE_DEAD)) begin
            an_d = ~(4'b0001 << slot_q);
            if (!(blink_q && fblink_d[slot_q])) begin
                seg_d = sel_seg;
                dp_d  = ~fdp_d[slot_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q    <= '0;
            slot_q   <= '0;
            frm_q    <= '0;
            blink_q  <= 1'b0;
            fdig_q   <= {4{CODE_BLANK}};
            fblink_q <= '0;
            fdp_q    <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            an_q     <= 4'hF;
            fs_q     <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            slot_q   <= slot_d;
            frm_q    <= frm_d;
            blink_q  <= blink_d;
            fdig_q   <= fdig_d;
            fblink_q <= fblink_d;
            fdp_q    <= fdp_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed tables and sequences plus randomized run against a time-based model.
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BF = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] dig0, dig1, dig2, dig3, blink_mask, dp_mask;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .dig0        (dig0),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    // Model state: t = enabled edges since the last clear; frame data captured at t % FRAME == 0.
    int         t;
    logic [3:0] m_dig [4];
    logic [3:0] m_blink, m_dp;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    logic [3:0] e_an;

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        case (c)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            4'd11:   return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic model_edge();
        int pre, slot, phase;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
        if (!rst) begin
            t = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'd10;
            m_blink = 4'h0; m_dp = 4'h0;
        end else if (!en) begin
            t = 0;
        end else begin
            if (t % FRAME == 0) begin
                m_dig[0] = dig0; m_dig[1] = dig1; m_dig[2] = dig2; m_dig[3] = dig3;
                m_blink = blink_mask; m_dp = dp_mask;
                e_fs = 1'b1;
            end
            pre   = t % SD;
            slot  = (t / SD) % 4;
            phase = ((t / FRAME) / BF) % 2;
            if (pre >= DC) begin
                e_an = 4'hF;
                e_an[slot] = 1'b0;
                if (!(phase == 1 && m_blink[slot])) begin
                    e_seg = ref_seg(m_dig[slot]);
                    e_dp  = ~m_dp[slot];
                end
            end
            t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        tests++;
        if (seg !== e_seg || dp !== e_dp || an !== e_an || frame_start !== e_fs) begin
            fails++;
            $display("FAIL model t=%0d: seg=%h dp=%b an=%h fs=%b, required seg=%h dp=%b an=%h fs=%b",
                     t, seg, dp, an, frame_start, e_seg, e_dp, e_an, e_fs);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic restart();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
    } dec_vec_t;

    typedef struct {
        int         slot;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } slot_vec_t;

    dec_vec_t  dec_tab [16];
    slot_vec_t slot_tab [4];

    initial begin
        dec_tab = '{
            '{4'd0, 7'h40}, '{4'd1, 7'h79}, '{4'd2, 7'h24}, '{4'd3, 7'h30},
            '{4'd4, 7'h19}, '{4'd5, 7'h12}, '{4'd6, 7'h02}, '{4'd7, 7'h78},
            '{4'd8, 7'h00}, '{4'd9, 7'h10}, '{4'd10, 7'h7F}, '{4'd11, 7'h3F},
            '{4'd12, 7'h7F}, '{4'd13, 7'h7F}, '{4'd14, 7'h7F}, '{4'd15, 7'h7F}
        };
        slot_tab = '{
            '{0, 7'h3F, 1'b1, 4'hE}, '{1, 7'h7F, 1'b1, 4'hD},
            '{2, 7'h7F, 1'b1, 4'hB}, '{3, 7'h40, 1'b0, 4'h7}
        };

        // Reset and frame alignment
        rst = 1'b0; en = 1'b1;
        dig0 = 4'd1; dig1 = 4'd2; dig2 = 4'd3; dig3 = 4'd4;
        blink_mask = 4'h0; dp_mask = 4'h0;
        t = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_an", 32'(an), 32'hF);
            check_val("rst_seg", 32'(seg), 32'h7F);
        end
        rst = 1'b1;
        // Snapshot coherence and dead time over two frames
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (k == 12) dig2 = 4'd8;
            if (k == 0) check_val("first_frame_start", 32'(frame_start), 32'h1);
            if (k >= 2 && k < 8) begin
                check_val("slot0_an", 32'(an), 32'hE);
                check_val("slot0_seg", 32'(seg), 32'h79);
            end
            if (k == 10) check_val("slot1_an", 32'(an), 32'hD);
            if (k % SD < DC) begin
                check_val("dead_an", 32'(an), 32'hF);
                check_val("dead_seg", 32'(seg), 32'h7F);
            end
            if (k == 20) check_val("coherent_slot2", 32'(seg), 32'h30);
            if (k == FRAME + 20) check_val("next_frame_slot2", 32'(seg), 32'h00);
        end

        // Decode table through slot 0
        for (int v = 0; v < 16; v++) begin
            dig0 = dec_tab[v].code;
            restart();
            for (int k = 0; k < 3; k++) tick();
            check_val($sformatf("decode_%0d", dec_tab[v].code), 32'(seg), 32'(dec_tab[v].seg));
        end

        // Blink on digit 0 across five frames
        dig0 = 4'd8; dig1 = 4'd5; blink_mask = 4'b0001;
        restart();
        for (int k = 0; k < 5 * FRAME; k++) begin
            tick();
            if (k % FRAME == 4) begin
                check_val("blink_an", 32'(an), 32'hE);
                check_val("blink_seg", 32'(seg), ((k / FRAME) % 4 < 2) ? 32'h00 : 32'h7F);
            end
            if (k % FRAME == 12) check_val("blink_other", 32'(seg), 32'h12);
        end

        // Special codes and decimal point
        dig0 = 4'd11; dig1 = 4'd10; dig2 = 4'd15; dig3 = 4'd0;
        blink_mask = 4'h0; dp_mask = 4'b1000;
        restart();
        for (int k = 0; k < FRAME; k++) begin
            tick();
            for (int v = 0; v < 4; v++) begin
                if (k == slot_tab[v].slot * SD + 5) begin
                    check_val($sformatf("codes_seg_s%0d", v), 32'(seg), 32'(slot_tab[v].seg));
                    check_val($sformatf("codes_dp_s%0d", v), 32'(dp), 32'(slot_tab[v].dp));
                    check_val($sformatf("codes_an_s%0d", v), 32'(an), 32'(slot_tab[v].an));
                end
            end
        end

        // en drop mid-slot 2, re-enable, then reset mid-slot 1
        dig0 = 4'd1; dig1 = 4'd2; dig2 = 4'd3; dig3 = 4'd4; dp_mask = 4'h0;
        restart();
        for (int k = 0; k < 2 * SD + 4; k++) tick();
        check_val("pre_drop_an", 32'(an), 32'hB);
        en = 1'b0;
        tick();
        check_val("en_off_an", 32'(an), 32'hF);
        check_val("en_off_seg", 32'(seg), 32'h7F);
        check_val("en_off_fs", 32'(frame_start), 32'h0);
        tick();
        en = 1'b1;
        tick();
        check_val("reen_fs", 32'(frame_start), 32'h1);
        tick(); tick();
        check_val("reen_an", 32'(an), 32'hE);
        for (int k = 0; k < SD + 2; k++) tick();
        check_val("pre_rst_an", 32'(an), 32'hD);
        rst = 1'b0;
        tick();
        check_val("rst_mid_an", 32'(an), 32'hF);
        check_val("rst_mid_seg", 32'(seg), 32'h7F);
        check_val("rst_mid_dp", 32'(dp), 32'h1);
        rst = 1'b1;

        // Randomized run against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 29) == 0) begin
                dig0 = 4'($urandom); dig1 = 4'($urandom);
                dig2 = 4'($urandom); dig3 = 4'($urandom);
                blink_mask = 4'($urandom); dp_mask = 4'($urandom);
            end
            en  = ($urandom_range(0, 299) != 0);
            rst = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexes the four display digit codes (dig0..dig3) produced by the game FSM onto one shared 4-digit common-anode seven-segment display.
- Sequences the anodes at a fixed slot rate, with anti-ghosting dead time at each slot start.
- Latches the digit codes once per scan frame so all four digits in a frame are coherent, and applies per-digit blink and decimal-point masks.
- Sits between the game FSM and the board display pins.

Parameters:
- SCAN_DIV, 100000: clocks per digit slot. Must be >= 2.
- DEAD_CYC, 1000: blanked clocks at the start of each slot. Must be < SCAN_DIV.
- BLINK_FRAMES, 125: frames per blink half-period.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- en  in  1  display enable.
- dig0  in  4  digit code, rightmost digit (anode 0).
- dig1  in  4  digit code, anode 1.
- dig2  in  4  digit code, anode 2.
- dig3  in  4  digit code, leftmost digit (anode 3).
- blink_mask  in  4  bit i=1 makes digit i blink.
- dp_mask  in  4  bit i=1 lights the decimal point of digit i.
- seg  out  7  segments, active-low; seg[0]=a through seg[6]=g.
- dp  out  1  decimal point, active-low.
- an  out  4  anodes, active-low; an[i] selects digit i.
- frame_start  out  1  one-clock pulse marking the first output cycle of slot 0.

Behaviour:
- Code map:
  - 0..9 display the decimal digit.
  - 10 and 12..15 display blank (seg=7'h7F).
  - 11 displays a dash (g only, seg=7'h3F).
  - Sample patterns: 8 -> 7'h00, 1 -> 7'h79, 0 -> 7'h40.
- Reset (rst=0 at a clk edge):
  - Counters are zeroed and blink_phase is 0.
  - Frame registers are loaded with code 10 and masks with 0.
  - Outputs: an=4'hF, seg=7'h7F, dp=1, frame_start=0.
- Counters:
  - pre counts 0..SCAN_DIV-1.
  - slot (0..3) advances when pre wraps; slot 3 wraps to 0.
  - frm counts 0..BLINK_FRAMES-1 and advances when slot 3 wraps.
  - blink_phase toggles when frm wraps.
- Snapshot:
  - In the cycle where pre==0 and slot==0, dig0..3, blink_mask and dp_mask are copied into the frame registers.
  - Input changes that occur mid-frame do not appear until the next frame.
- Output latency:
  - seg, dp, an and frame_start are registered. They reflect the counter and frame-register state one clock later.
  - frame_start is high exactly in the output cycle corresponding to pre==0, slot==0.
  - Outputs use the newly snapshotted values in that same cycle.
- Dead time: while pre < DEAD_CYC, outputs are an=4'hF, seg=7'h7F, dp=1.
- Active part of slot s (pre >= DEAD_CYC):
  - an has only bit s low.
  - seg is the decode of frame digit s.
  - dp is the inverse of frame dp_mask[s].
- Blink: when blink_phase=1 and frame blink_mask[s]=1, seg is 7'h7F and dp is 1. The anode is still driven.
- en=0:
  - Outputs are forced off (an=4'hF, seg=7'h7F, dp=1, frame_start=0).
  - pre, slot, frm and blink_phase are cleared.
  - When en returns to 1, a fresh frame starts: a snapshot is taken on the first enabled edge, and frame_start follows one clock later.
- Reset takes priority over en. A reset during a slot aborts the scan with no residual output.
- Simultaneous wraps (pre, slot, frm and the blink toggle on the same edge) all resolve in that single edge. The snapshot in the following cycle then sees the new blink_phase.

Decomposition:
- Shared package:
  - Code constants CODE_BLANK=10 and CODE_DASH=11.
  - SEG_OFF=7'h7F and SEG_DASH=7'h3F.
  - The 16-entry code-to-segment table.
- Sub-module seg7_decode: purely combinational, 4-bit code in, 7-bit active-low seg out. It is instantiated once, on the selected frame digit.

Test Plan:
- All tests use SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2.
- Test 1 (reset and frame alignment):
  - Stimulus: hold rst=0 for 3 clocks with en=1 and dig0..3=1,2,3,4, then release.
  - Required: an=4'hF and seg=7'h7F while in reset. First frame_start 1 clock after the first enabled edge. an=4'hE with seg=7'h79 during slot-0 cycles 2..7. Slot 1 begins 8 clocks later with an=4'hD.
- Test 2 (snapshot coherence):
  - Stimulus: change dig2 from 3 to 8 during slot 1.
  - Required: slot 2 of the current frame shows 7'h30. The next frame shows 7'h00.
- Test 3 (dead time):
  - Stimulus: observe each slot transition.
  - Required: exactly 2 cycles of an=4'hF and seg=7'h7F at every slot boundary.
- Test 4 (blink):
  - Stimulus: blink_mask=4'b0001, dig0=8.
  - Required: frames 0-1 show seg=7'h00 in slot 0, frames 2-3 show 7'h7F with an=4'hE, and the pattern repeats every 4 frames. Other digits are unaffected.
- Test 5 (codes and dp):
  - Stimulus: dig=11,10,15,0 with dp_mask=4'b1000.
  - Required: slots show 7'h3F, 7'h7F, 7'h7F, 7'h40. dp=0 only in slot 3.
- Test 6 (en and reset mid-operation):
  - Stimulus: drop en mid-slot 2, then reassert it.
  - Required: outputs go off on the next clock. After reassertion, the scan restarts at slot 0 with frame_start. Asserting rst=0 mid-slot likewise produces off outputs on the next clock.
